// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, marks frame edges, flags errors.
// Define GMII_RX_FCS_CHECK_EN to add the CRC-32 FCS check (fcs_bad otherwise 0).
module gmii_rx_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rxclk,
    input  logic        rst_n,
    input  logic        gmii_rxctrl,
    input  logic [7:0]  gmii_rxdata,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [15:0] rx_len,
    output logic        rx_err,
    output logic [2:0]  rx_err_code,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [7:0]  hold_data;
    logic        hold_vld;
    logic        hold_first;
    logic [15:0] len_cnt;
    logic [15:0] len_next;
    logic [15:0] err_inc;
    logic [2:0]  err_code;
    logic        fcs_bad;

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_next;

    // Byte-wide step of the reflected CRC-32 over the incoming byte
    always_comb begin
        crc_next = crc ^ {24'h0, gmii_rxdata};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB88320)
                                   : (crc_next >> 1);
        end
    end

    // CRC register: seeded on SFD, advanced on every frame byte
    always_ff @(posedge gmii_rxclk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (gmii_rxctrl) begin
            if (state == PREAMBLE && gmii_rxdata == 8'hD5) begin
                crc <= 32'hFFFFFFFF;
            end else if (state == DATA) begin
                crc <= crc_next;
            end
        end
    end

    assign fcs_bad = (crc != 32'hDEBB20E3);
`else
    assign fcs_bad = 1'b0;
`endif

    // Saturating increments and the end-of-frame status word
    always_comb begin
        err_inc  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
        len_next = (len_cnt == 16'hFFFF) ? len_cnt : len_cnt + 16'd1;
        err_code = {fcs_bad, (len_cnt > MAX_L), (len_cnt < MIN_L)};
    end

    // Receive FSM; one-byte hold stage lets the last byte carry rx_eof
    always_ff @(posedge gmii_rxclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            hold_data   <= '0;
            hold_vld    <= 1'b0;
            hold_first  <= 1'b0;
            len_cnt     <= '0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_sof      <= 1'b0;
            rx_eof      <= 1'b0;
            rx_len      <= '0;
            rx_err      <= 1'b0;
            rx_err_code <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_sof      <= 1'b0;
            rx_eof      <= 1'b0;
            rx_len      <= '0;
            rx_err      <= 1'b0;
            rx_err_code <= '0;
            unique case (state)
                IDLE: begin
                    if (gmii_rxctrl) begin
                        if (gmii_rxdata == 8'h55) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state   <= DROP;
                            err_cnt <= err_inc;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rxctrl) begin
                        state <= IDLE;
                    end else if (gmii_rxdata == 8'hD5) begin
                        state    <= DATA;
                        len_cnt  <= '0;
                        hold_vld <= 1'b0;
                    end else if (gmii_rxdata == 8'h55 && pre_cnt < 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        state   <= DROP;
                        err_cnt <= err_inc;
                    end
                end
                DATA: begin
                    if (hold_vld) begin
                        rx_valid <= 1'b1;
                        rx_data  <= hold_data;
                        rx_sof   <= hold_first;
                    end
                    if (gmii_rxctrl) begin
                        hold_data  <= gmii_rxdata;
                        hold_vld   <= 1'b1;
                        hold_first <= (len_cnt == 16'd0);
                        len_cnt    <= len_next;
                    end else begin
                        state    <= IDLE;
                        hold_vld <= 1'b0;
                        if (hold_vld) begin
                            rx_eof      <= 1'b1;
                            rx_len      <= len_cnt;
                            rx_err_code <= err_code;
                            rx_err      <= |err_code;
                            if (|err_code) begin
                                err_cnt <= err_inc;
                            end else begin
                                frame_cnt <= frame_cnt + 32'd1;
                            end
                        end else begin
                            err_cnt <= err_inc;
                        end
                    end
                end
                DROP: begin
                    if (!gmii_rxctrl) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 Parameter MIN_LEN, default 64: minimum legal frame length in bytes (DA through FCS).
REQ-002 Parameter MAX_LEN, default 1518: maximum legal frame length in bytes.
REQ-003 gmii_rxclk  in  1: sole clock, all logic on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous, active-low.
REQ-005 gmii_rxctrl  in  1: receive data valid.
REQ-006 gmii_rxdata  in  8: receive byte.
REQ-007 rx_valid  out  1: rx_data holds a frame byte this cycle.
REQ-008 rx_data  out  8: frame byte, preamble and SFD removed.
REQ-009 rx_sof  out  1: marks the first frame byte, qualified by rx_valid.
REQ-010 rx_eof  out  1: marks the last frame byte, qualified by rx_valid.
REQ-011 rx_len  out  16: byte count of the frame, valid with rx_eof.
REQ-012 rx_err  out  1: frame bad, valid with rx_eof.
REQ-013 rx_err_code  out  3: {fcs_bad, too_long, too_short}, valid with rx_eof.
REQ-014 frame_cnt  out  32: good frames received.
REQ-015 err_cnt  out  16: bad or dropped frames.

Function
REQ-016 FSM states: IDLE, PREAMBLE, DATA, DROP.
REQ-017 IDLE transitions: rxctrl=1 with data 0x55 -> PREAMBLE (pre_cnt=1); rxctrl=1 with any other byte -> DROP; rxctrl=0 -> stay in IDLE.
REQ-018 PREAMBLE transitions: 0x55 with pre_cnt<7 -> stay, pre_cnt+1; 0xD5 -> DATA; 0x55 with pre_cnt=7, or any other byte -> DROP; rxctrl=0 -> IDLE, no output, no count.
REQ-019 DATA behaviour: each rxctrl=1 byte is a frame byte; rxctrl=0 ends the frame and returns to IDLE.
REQ-020 Output timing: a frame byte sampled on edge k appears on rx_data with rx_valid=1 after edge k+1; the two-cycle latency is fixed.
REQ-021 rx_eof: asserted with a byte when rxctrl=0 is sampled on the edge after that byte.
REQ-022 rx_sof: asserted with the first byte; a one-byte frame carries rx_sof and rx_eof together.
REQ-023 rx_len: counts frame bytes and saturates at 0xFFFF.
REQ-024 too_short is set when len<MIN_LEN; too_long is set when len>MAX_LEN; oversize bytes still pass through.
REQ-025 rx_err is the OR of rx_err_code bits.
REQ-026 Zero-byte frame (SFD followed immediately by rxctrl=0): no output, err_cnt+1.
REQ-027 DROP: no output, stay until rxctrl=0, then IDLE; err_cnt+1 on DROP entry.
REQ-028 Counters at rx_eof: frame_cnt+1 (wraps) when rx_err=0; err_cnt+1 (saturates at 0xFFFF) when rx_err=1.
REQ-029 Back-to-back frames: a single rxctrl=0 cycle between frames is sufficient; the second frame is received intact.

Reset
REQ-030 While rst_n=0: all outputs 0, FSM in IDLE, all counters and the CRC register cleared, immediately and independent of gmii_rxclk.
REQ-031 Reset mid-frame: the partial frame is discarded, with no rx_eof and no count.
REQ-032 After release: if rxctrl=1 with data not equal to 0x55 on the first edge, enter DROP.

Configuration
REQ-033 Macro GMII_RX_FCS_CHECK_EN, when defined: CRC-32 runs over all frame bytes including the FCS.
- Reflected polynomial 0xEDB88320, LSB first, init 0xFFFFFFFF, reset at SFD.
- fcs_bad = (register value after the last byte != 0xDEBB20E3).
REQ-034 Macro GMII_RX_FCS_CHECK_EN, when undefined: no CRC logic is present, and fcs_bad is constant 0.
REQ-035 Latency and all other behaviour are identical with and without the macro.

Verification
REQ-036 7x0x55, 0xD5, 64-byte frame with valid FCS:
- rx_sof on byte 1, 64 rx_valid cycles, rx_eof on byte 64.
- rx_len=64, rx_err=0, frame_cnt=1.
- First rx_valid 2 edges after the first data byte is sampled.
REQ-037 60-byte frame with valid FCS -> rx_err=1, rx_err_code=3'b001, err_cnt=1.
REQ-038 64-byte frame with byte 20 flipped:
- Macro defined: rx_err_code=3'b100.
- Macro undefined: rx_err=0.
REQ-039 Preamble 0x55,0x55,0x55,0x57 followed by 40 bytes -> no rx_valid, err_cnt=1; the next good frame is received with frame_cnt=1.
REQ-040 Two 64-byte good frames separated by 12 idle cycles, then two separated by 1 idle cycle -> frame_cnt=4, no bytes lost.
REQ-041 rst_n pulsed low during byte 30 of a frame:
- Outputs 0 asynchronously, counters 0.
- The following 1518-byte good frame gives rx_len=1518, rx_err=0.
